demux1to4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer for the CNN datapath. It steers each word of one valid/ready input stream into one of four output channels. Each output channel has a one-entry holding register. The steering target comes either from a per-word select or from an internal round-robin pointer. It sits between a shared producer, such as a memory read port or the result bus, and four parallel consumers, such as the convolution lanes. It is the distribution counterpart of the 4-to-1 selection muxes used on the gathering side.

---
 rtl/demux1to4_stream.sv | 70 +++++++
 tb/tb_demux1to4_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted input word into one
// of four one-entry channel registers, chosen by in_sel or by a round-robin pointer.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 16
`endif

module demux1to4_stream #(
  parameter int DATA_W = `INTERNAL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              rr_mode,
  input  logic              rr_clear,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        rr_ptr
);

  logic [3:0]        v;
  logic [DATA_W-1:0] data_q [4];
  logic [1:0]        tgt;
  logic              accept;

  assign tgt = rr_mode ? rr_ptr : in_sel;

  // A full target slot that drains this cycle can still take a word (pass-through).
  assign in_ready = ~v[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every channel and the
  // pointer see the pre-edge values of v, rr_ptr and tgt regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v      <= '0;
      rr_ptr <= '0;
      // NOTE: the holding registers are visible on ports with a defined reset value of 0,
      // so unlike a plain storage array they are reset here.
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && tgt == 2'(k)) begin
          v[k]      <= 1'b1;
          data_q[k] <= in_data;
        end else if (v[k] && out_ready[k]) begin
          v[k] <= 1'b0;
        end
      end
      // Clear wins over advance; the word accepted this cycle already used the old pointer.
      if (rr_clear)
        rr_ptr <= '0;
      else if (accept && rr_mode)
        rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign out_valid = v;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Bench for demux1to4_stream: directed vector table, a mid-stream reset sequence,
// and a randomized run checked against a channel-occupancy reference model.
module tb_demux1to4_stream;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          rr_mode;
  logic          rr_clear;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0]    rr_ptr;
  logic [DW-1:0] dout [4];

  int n_vec = 0;
  int n_bad = 0;

  demux1to4_stream #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .rr_mode(rr_mode), .rr_clear(rr_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  assign dout[0] = out_data0;
  assign dout[1] = out_data1;
  assign dout[2] = out_data2;
  assign dout[3] = out_data3;

  typedef struct {
    logic          vld;
    logic [1:0]    sel;
    logic          rr;
    logic          clr;
    logic [3:0]    rdy;
    logic [DW-1:0] d;
    logic          x_ready;   // in_ready before the edge
    logic [3:0]    x_valid;   // out_valid after the edge
    logic [1:0]    x_ptr;     // rr_ptr after the edge
    logic [1:0]    x_ch;      // channel whose data is checked after the edge
    logic [DW-1:0] x_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [1:0] sel, logic rr, logic clr,
                              logic [3:0] rdy, logic [DW-1:0] d, logic x_ready,
                              logic [3:0] x_valid, logic [1:0] x_ptr,
                              logic [1:0] x_ch, logic [DW-1:0] x_data);
    vec_t r;
    r.vld = vld; r.sel = sel; r.rr = rr; r.clr = clr; r.rdy = rdy; r.d = d;
    r.x_ready = x_ready; r.x_valid = x_valid; r.x_ptr = x_ptr;
    r.x_ch = x_ch; r.x_data = x_data;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic rr,
                       input logic clr, input logic [3:0] rdy, input logic [DW-1:0] d);
    in_valid = vld; in_sel = sel; rr_mode = rr; rr_clear = clr; out_ready = rdy; in_data = d;
  endtask

  // Reference model state: occupancy, contents and pointer of the four channels.
  logic [3:0]    mv;
  logic [DW-1:0] md [4];
  int            mptr;

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 4'h0, '0);

    // Reset values
    #2;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset rr_ptr", 32'(rr_ptr), 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("reset out_data%0d", k), 32'(dout[k]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table: vld sel rr clr rdy data | ready valid ptr ch data
    tbl.push_back(mk(1, 2, 0, 0, 4'b1111, 16'hA0, 1, 4'b0100, 0, 2, 16'hA0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b1111, 16'hA1, 1, 4'b0001, 0, 0, 16'hA1));
    tbl.push_back(mk(1, 3, 0, 0, 4'b1111, 16'hA2, 1, 4'b1000, 0, 3, 16'hA2));
    tbl.push_back(mk(1, 2, 0, 0, 4'b1111, 16'hA3, 1, 4'b0100, 0, 2, 16'hA3));
    // backpressure on channel 1
    tbl.push_back(mk(1, 1, 0, 0, 4'b1101, 16'h11, 1, 4'b0010, 0, 1, 16'h11));
    tbl.push_back(mk(1, 1, 0, 0, 4'b1101, 16'h22, 0, 4'b0010, 0, 1, 16'h11));
    tbl.push_back(mk(1, 1, 0, 0, 4'b1111, 16'h22, 1, 4'b0010, 0, 1, 16'h22));
    tbl.push_back(mk(0, 1, 0, 0, 4'b1111, 16'h99, 1, 4'b0000, 0, 1, 16'h22));
    // independent drain of non-target channels
    tbl.push_back(mk(1, 0, 0, 0, 4'b1111, 16'h30, 1, 4'b0001, 0, 0, 16'h30));
    tbl.push_back(mk(1, 3, 0, 0, 4'b0110, 16'h33, 1, 4'b1001, 0, 3, 16'h33));
    tbl.push_back(mk(1, 1, 0, 0, 4'b1001, 16'h44, 1, 4'b0010, 0, 1, 16'h44));
    // round robin, in_sel ignored
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h00, 1, 4'b0001, 1, 0, 16'h00));
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h01, 1, 4'b0010, 2, 1, 16'h01));
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h02, 1, 4'b0100, 3, 2, 16'h02));
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h03, 1, 4'b1000, 0, 3, 16'h03));
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h04, 1, 4'b0001, 1, 0, 16'h04));
    tbl.push_back(mk(1, 3, 1, 0, 4'b1111, 16'h05, 1, 4'b0010, 2, 1, 16'h05));
    // fill channel 2 in sel mode, then stall round robin on it
    tbl.push_back(mk(1, 2, 0, 0, 4'b1011, 16'h66, 1, 4'b0100, 2, 2, 16'h66));
    tbl.push_back(mk(1, 0, 1, 0, 4'b1011, 16'h77, 0, 4'b0100, 2, 2, 16'h66));
    tbl.push_back(mk(1, 0, 1, 0, 4'b1111, 16'h77, 1, 4'b0100, 3, 2, 16'h77));
    // rr_clear together with an accept at pointer 3
    tbl.push_back(mk(1, 0, 1, 1, 4'b1111, 16'h55, 1, 4'b1000, 0, 3, 16'h55));
    tbl.push_back(mk(0, 0, 0, 0, 4'b1111, 16'h00, 1, 4'b0000, 0, 3, 16'h55));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].rr, tbl[i].clr, tbl[i].rdy, tbl[i].d);
      #3;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].x_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].x_valid));
      check($sformatf("vec%0d rr_ptr", i), 32'(rr_ptr), 32'(tbl[i].x_ptr));
      check($sformatf("vec%0d out_data%0d", i, tbl[i].x_ch), 32'(dout[tbl[i].x_ch]),
            32'(tbl[i].x_data));
    end

    // Mid-stream reset: fill all four channels, leave rr_ptr at 3, reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 1'b1, 1'b0, 4'h0, 16'(16'hC0 + i));
      @(posedge clk); #1;
    end
    drive(1'b1, 2'd3, 1'b0, 1'b0, 4'h0, 16'hC3);
    @(posedge clk); #1;
    check("fill out_valid", 32'(out_valid), 32'hF);
    check("fill rr_ptr", 32'(rr_ptr), 32'd3);
    drive(1'b0, 2'd3, 1'b0, 1'b0, 4'h0, 16'h0);
    #3;
    reset = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'h0);
    check("async reset rr_ptr", 32'(rr_ptr), 32'd0);
    check("async reset out_data3", 32'(out_data3), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 1'b0, 4'h0, 16'h0);
    #1;
    check("post reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("post reset out_valid", 32'(out_valid), 32'h0);

    // Randomized run against the reference model (starts from the reset state)
    mv = '0; mptr = 0;
    for (int k = 0; k < 4; k++) md[k] = '0;
    begin
      logic          vld, rr, clr, stalled, exp_rdy, acc;
      logic [1:0]    sel;
      logic [3:0]    rdy;
      logic [DW-1:0] d;
      int            t;
      stalled = 1'b0;
      vld = 1'b0; rr = 1'b0; sel = 2'd0; d = '0;
      for (int c = 0; c < 3000; c++) begin
        if (!stalled) begin
          vld = ($urandom_range(0, 3) != 0);
          rr  = ($urandom_range(0, 1) == 1);
          sel = 2'($urandom_range(0, 3));
          d   = DW'($urandom);
        end
        clr = ($urandom_range(0, 15) == 0);
        rdy = 4'($urandom);
        drive(vld, sel, rr, clr, rdy, d);

        t       = rr ? mptr : int'(sel);
        exp_rdy = !mv[t] || rdy[t];
        acc     = vld && exp_rdy;
        #3;
        check("rand in_ready", 32'(in_ready), 32'(exp_rdy));

        for (int k = 0; k < 4; k++) begin
          if (acc && t == k) begin
            mv[k] = 1'b1;
            md[k] = d;
          end else if (mv[k] && rdy[k]) begin
            mv[k] = 1'b0;
          end
        end
        if (clr) mptr = 0;
        else if (acc && rr) mptr = (mptr + 1) % 4;
        stalled = vld && !exp_rdy;

        @(posedge clk); #1;
        check("rand out_valid", 32'(out_valid), 32'(mv));
        check("rand rr_ptr", 32'(rr_ptr), 32'(mptr));
        for (int k = 0; k < 4; k++)
          check($sformatf("rand out_data%0d", k), 32'(dout[k]), 32'(md[k]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
